// File: rtl/logic_unit_pkg.sv
// Shared definitions for the registered logic unit: operation encoding and op type.
package logic_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_NAND = 3'd1;
  localparam op_t OP_OR   = 3'd2;
  localparam op_t OP_NOR  = 3'd3;
  localparam op_t OP_NOT  = 3'd4;
  localparam op_t OP_XOR  = 3'd5;
  localparam op_t OP_XNOR = 3'd6;
  localparam op_t OP_PASS = 3'd7;

endpackage

// File: rtl/logic_gate_core.sv
// Combinational bitwise gate, the WIDTH-parametrised successor of the two-input gate block.
module logic_gate_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] y
);

  // NOT and PASS look only at a; every 3-bit code is a defined operation.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_NOT:  y = ~a;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Logic unit with a one-stage valid/ready result register, zero/parity flags and an
// accumulate mode that folds an operand stream into an internal register.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] core_y;
  op_t              core_op;
  logic             accept;

  // A clear in the same cycle as an accumulating beat makes the beat see ACC_INIT.
  assign acc_eff   = acc_clear ? ACC_INIT : acc;
  assign operand_b = acc_mode ? acc_eff : b;
  assign core_op   = op_t'(op);

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  logic_gate_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (a),
    .b  (operand_b),
    .op (core_op),
    .y  (core_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      parity    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= core_y;
      zero      <= (core_y == '0);
      parity    <= ^core_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator writes only on accumulating beats; otherwise a clear wins, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= ACC_INIT;
    end else if (accept && acc_mode) begin
      acc <= core_y;
    end else if (acc_clear) begin
      acc <= ACC_INIT;
    end
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's two-input gate block.
- Applies one selectable bitwise operation to WIDTH-bit operands (AND, NAND, OR, NOR, NOT, XOR, XNOR, PASS).
- Result is returned through a one-stage valid/ready pipeline register with zero and parity flags.
- An accumulate mode folds a stream of operands into an internal register. Sits between operand producers and any downstream consumer that may stall.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- ACC_INIT, 0, value loaded into the accumulator on reset and on acc_clear (WIDTH bits).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored when acc_mode=1.
- op  input  3  operation select: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 NOT(a), 5 XOR, 6 XNOR, 7 PASS(a).
- acc_mode  input  1  1: B operand is the accumulator; the result is also written to the accumulator.
- acc_clear  input  1  load ACC_INIT into the accumulator.
- out_valid  output  1  result register holds a valid beat.
- out_ready  input  1  consumer takes the beat.
- result  output  WIDTH  registered result.
- zero  output  1  registered (result == 0).
- parity  output  1  registered XOR-reduction of result.
- acc  output  WIDTH  current accumulator value.

Behaviour:
- Reset (rst=1 at edge): out_valid=0, result=0, zero=1, parity=0, acc=ACC_INIT. Reset overrides every other input, including mid-transfer; a held beat is discarded.
- in_ready = !out_valid || out_ready. This is combinational and gives full throughput of 1 beat/cycle.
- Accept = in_valid && in_ready.
  - On accept, result/zero/parity load from the current operands and out_valid=1 next cycle. Latency is 1 cycle.
  - If there is no accept and out_ready=1, out_valid clears to 0.
  - If there is no accept and out_ready=0, the register holds all outputs unchanged (stable while stalled).
- Operand B = acc_mode ? acc_eff : b, where acc_eff = acc_clear ? ACC_INIT : acc.
- Accumulator update at the edge, in priority order:
  - accept && acc_mode: acc <= computed result.
  - else acc_clear: acc <= ACC_INIT.
  - else hold.
- acc_clear coincident with an accumulating accept therefore operates on ACC_INIT and stores the new result.
- Accumulator is never written when acc_mode=0, except by clear.
- NOT and PASS ignore B entirely, including in acc_mode. In acc_mode these ops still write their result into acc.
- All operations are pure bitwise; no carries and no width growth. The result is exactly WIDTH bits.
- op values are all defined; there is no illegal encoding.
- in_valid=0 with acc_clear=1 still clears the accumulator and does not touch the output register.
- Inputs are sampled only on accept. a/b/op changes while stalled have no effect.

Decomposition:
- Package logic_unit_pkg: 3-bit op localparams (OP_AND..OP_PASS) and the op typedef.
- Sub-module logic_gate_core: purely combinational, parameter WIDTH. Ports a, b, op -> y. It is the generalised successor of the existing gate block.
- The top level holds the handshake register, accumulator and flag generation.

Test Plan (WIDTH=8, ACC_INIT=0):
- Reset then idle: rst high 2 cycles -> out_valid=0, zero=1, acc=0x00, in_ready=1.
- All ops: a=0xC3, b=0xA5, out_ready=1, op 0..7 back-to-back, one beat per cycle. Required results one cycle later: 0x81, 0x7E, 0xE7, 0x18, 0x3C, 0x66, 0x99, 0xC3. Parity flags 0, 0, 0, 0, 0, 0, 0, 0. zero=0 throughout.
- Backpressure: accept a=0xF0, b=0x0F, op=XOR, then out_ready=0 for 3 cycles while in_valid=1 with a=0x11. Required: result=0xFF held, in_ready=0, and no second accept. After out_ready=1, 0xFF transfers and the new beat is accepted the same cycle.
- Accumulate: acc_clear=1 for one cycle, then acc_mode=1, op=OR, beats a=0x01, 0x04, 0x80. Required: acc=0x01, 0x05, 0x85, and result beats equal those values.
- Clear + accumulate collision: acc=0x85, op=XOR, acc_mode=1, acc_clear=1, a=0x0F accepted. Required: result=0x0F, acc=0x0F.
- Reset mid-stall: out_valid=1 with out_ready=0, then rst pulse. Required: out_valid=0, result=0x00, acc=0x00 the next cycle.
